divider_unit: RTL and testbench
===============================

Name: divider_unit

Overview:
- Sequential radix-2 non-restoring integer divider, signed or unsigned.
- Inverse companion of the shift/add multiplier datapath; sits beside it in the multiply/divide unit.
- Accepts operands on a start pulse.
- Returns quotient and remainder with a done pulse after a fixed latency.

Parameters:
parallelism, 32, operand/result width in bits (>=4)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-high reset
start  input  1  request; sampled on rising clk edge when busy=0
usigned  input  1  1 = unsigned operands, 0 = two's-complement; sampled with start
dividend  input  parallelism  numerator; sampled with start
divisor  input  parallelism  denominator; sampled with start
busy  output  1  operation in progress; start ignored while high
done  output  1  single-cycle pulse, results valid
quotient  output  parallelism  registered quotient
remainder  output  parallelism  registered remainder
div_by_zero  output  1  registered flag, set with done when divisor was 0

Behaviour:
- Reset (async, rst=1): state IDLE; busy=0, done=0, quotient=0, remainder=0, div_by_zero=0; internal registers and counter cleared.
- Reset mid-operation aborts immediately; no done is produced.
- States and transitions:
  - IDLE: start=1 -> LOAD.
  - LOAD: one cycle. Latch |dividend|, |divisor| (sign-corrected to parallelism+1 bits as in the multiplier), sign of quotient and sign of dividend, special-case flags. -> ITER.
  - ITER: exactly parallelism cycles; counter counts 0..parallelism-1; terminal count -> FIX.
  - FIX: one cycle. If partial remainder is negative, add divisor back. Apply signs. -> DONE.
  - DONE: done=1 for one cycle, outputs loaded this cycle. start=1 -> LOAD (back-to-back), else -> IDLE.
- busy=1 in LOAD, ITER, FIX; busy=0 in IDLE and DONE.
- Latency: start accepted at edge k; done high from edge k+parallelism+2 to k+parallelism+3.
- quotient/remainder/div_by_zero change only on entry to DONE; held until the next DONE.
- start while busy=1: ignored, operands not sampled.
- ITER step, partial remainder P of parallelism+1 bits:
  - if P>=0: P=2P+bit-D; if P<0: P=2P+bit+D.
  - bit = next dividend MSB.
  - quotient bit = ~sign(new P), shifted into the quotient register.
  - FIX converts the non-restoring quotient digits.
- Signed results: quotient truncates toward zero; remainder takes the dividend's sign; dividend = quotient*divisor + remainder.
- Divisor = 0: quotient = all ones, remainder = dividend, div_by_zero=1, either signedness.
- Signed overflow (dividend = most-negative, divisor = -1): quotient = dividend, remainder = 0, div_by_zero=0.
- Unsigned mode treats the MSB as magnitude; no overflow case.
- Without the optional feature, special cases still take full latency; iteration results are discarded and the special values are loaded in DONE.

Optional Feature:
- Macro: DIV_FAST_SPECIAL_EN.
- Defined: a divide-by-zero or signed-overflow operation goes LOAD -> DONE directly; done high from edge k+1 to k+2.
- Undefined: all operations use the full parallelism+3-cycle latency.
- Result values are identical in both builds.

Test Plan:
- Unsigned 100/7, parallelism=32 -> quotient=14, remainder=2, div_by_zero=0; done exactly at edge k+34.
- Signed -100/7 (0xFFFFFF9C/0x00000007) -> quotient=0xFFFFFFF2, remainder=0xFFFFFFFE.
- Signed 100/-7 -> quotient=0xFFFFFFF2, remainder=2.
- Unsigned 0xFFFFFFFF/1 -> quotient=0xFFFFFFFF, remainder=0.
- Divide by zero: dividend 0x12345678, divisor 0, signed -> quotient=0xFFFFFFFF, remainder=0x12345678, div_by_zero=1; done at k+34, or k+1 with DIV_FAST_SPECIAL_EN.
- Overflow: 0x80000000 / 0xFFFFFFFF signed -> quotient=0x80000000, remainder=0, div_by_zero=0.
- Control:
  - start pulsed at cycle 5 of an operation -> ignored; the first result is unchanged.
  - rst asserted mid-ITER -> busy=0, all outputs 0 immediately, no done.
  - back-to-back start in DONE -> second done parallelism+3 cycles later.

Source files
------------

// File: rtl/divider_unit.sv
// Sequential radix-2 non-restoring divider, signed or unsigned, with a fixed latency.
// Optional macro DIV_FAST_SPECIAL_EN: divide-by-zero and signed overflow skip straight to DONE.
module divider_unit #(
    parameter int parallelism = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   usigned,
    input  logic [parallelism-1:0] dividend,
    input  logic [parallelism-1:0] divisor,
    output logic                   busy,
    output logic                   done,
    output logic [parallelism-1:0] quotient,
    output logic [parallelism-1:0] remainder,
    output logic                   div_by_zero
);

    localparam int W     = parallelism;
    localparam int CNT_W = $clog2(W);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(W - 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_ITER = 3'd2;
    localparam logic [2:0] S_FIX  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]       state;
    logic [CNT_W-1:0] count;
    logic [W-1:0]     in_a, in_b;
    logic             in_usg;
    logic [W-1:0]     a_sh;
    logic [W:0]       d_mag;
    logic [W:0]       p_rem;
    logic [W-1:0]     q_reg;
    logic             neg_q, neg_r, is_dz, is_ovf;

    logic             a_neg, b_neg, dz_c, ovf_c;
    logic [W-1:0]     a_abs, b_abs;
    logic [W:0]       shifted, p_next, rem_fix;
    logic [W-1:0]     rem_mag, q_fin, r_fin;
    logic             sel_dz, sel_ovf;
    logic [W-1:0]     res_q, res_r;

    // Operand conditioning from the raw operands captured on start; used in LOAD.
    always_comb begin
        a_neg = ~in_usg & in_a[W-1];
        b_neg = ~in_usg & in_b[W-1];
        a_abs = a_neg ? (~in_a + 1'b1) : in_a;
        b_abs = b_neg ? (~in_b + 1'b1) : in_b;
        dz_c  = (in_b == '0);
        ovf_c = ~in_usg && (in_a == {1'b1, {(W-1){1'b0}}}) && (in_b == '1);
    end

    // One non-restoring step: the new quotient bit is the complement of the new sign.
    always_comb begin
        shifted = {p_rem[W-1:0], a_sh[W-1]};
        p_next  = p_rem[W] ? (shifted + d_mag) : (shifted - d_mag);
    end

    always_comb begin
        rem_fix = p_rem[W] ? (p_rem + d_mag) : p_rem;
        rem_mag = rem_fix[W-1:0];
        q_fin   = neg_q ? (~q_reg + 1'b1) : q_reg;
        r_fin   = neg_r ? (~rem_mag + 1'b1) : rem_mag;
        sel_dz  = (state == S_LOAD) ? dz_c  : is_dz;
        sel_ovf = (state == S_LOAD) ? ovf_c : is_ovf;
        res_q   = q_fin;
        res_r   = r_fin;
        if (sel_dz) begin
            res_q = '1;
            res_r = in_a;
        end else if (sel_ovf) begin
            res_q = in_a;
            res_r = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            count       <= '0;
            in_a        <= '0;
            in_b        <= '0;
            in_usg      <= 1'b0;
            a_sh        <= '0;
            d_mag       <= '0;
            p_rem       <= '0;
            q_reg       <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            is_dz       <= 1'b0;
            is_ovf      <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        in_a   <= dividend;
                        in_b   <= divisor;
                        in_usg <= usigned;
                        state  <= S_LOAD;
                    end else begin
                        state  <= S_IDLE;
                    end
                end
                S_LOAD: begin
                    a_sh   <= a_abs;
                    d_mag  <= {1'b0, b_abs};
                    p_rem  <= '0;
                    q_reg  <= '0;
                    neg_q  <= a_neg ^ b_neg;
                    neg_r  <= a_neg;
                    is_dz  <= dz_c;
                    is_ovf <= ovf_c;
                    count  <= '0;
`ifdef DIV_FAST_SPECIAL_EN
                    if (dz_c || ovf_c) begin
                        quotient    <= res_q;
                        remainder   <= res_r;
                        div_by_zero <= sel_dz;
                        state       <= S_DONE;
                    end else begin
                        state       <= S_ITER;
                    end
`else
                    state  <= S_ITER;
`endif
                end
                S_ITER: begin
                    p_rem <= p_next;
                    q_reg <= {q_reg[W-2:0], ~p_next[W]};
                    a_sh  <= {a_sh[W-2:0], 1'b0};
                    if (count == LAST) begin
                        state <= S_FIX;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                S_FIX: begin
                    quotient    <= res_q;
                    remainder   <= res_r;
                    div_by_zero <= sel_dz;
                    state       <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy = (state == S_LOAD) || (state == S_ITER) || (state == S_FIX);
    assign done = (state == S_DONE);

endmodule

// File: tb/tb_divider_unit.sv
// Directed self-checking bench for divider_unit (parallelism = 32) with hand-computed results.
// Honours DIV_FAST_SPECIAL_EN for the expected latency of special-case operations.
module tb_divider_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        usigned;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    int total = 0;
    int bad   = 0;

    localparam int FULL_LAT = 35;
`ifdef DIV_FAST_SPECIAL_EN
    localparam int SPEC_LAT = 2;
`else
    localparam int SPEC_LAT = 35;
`endif

    divider_unit #(.parallelism(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .usigned     (usigned),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // Counts edges from the first one after the call until done is seen; start drops after the first edge.
    task automatic waitForDone(input int inject_at, output int n, output bit seen);
        n = 0;
        seen = 1'b0;
        while (!seen && n < 200) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            n++;
            if (done) seen = 1'b1;
            else if (n == inject_at) begin
                start    = 1'b1;
                usigned  = 1'b1;
                dividend = 32'd1000;
                divisor  = 32'd3;
            end
        end
    endtask

    task automatic applyStimulus(input bit usg, input logic [31:0] a, input logic [31:0] b,
                                 input int inject_at, output int n);
        bit seen;
        usigned  = usg;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        waitForDone(inject_at, n, seen);
        checkOutput("done_seen", 32'(seen), 32'd1);
    endtask

    task automatic runCase(input string tag, input bit usg, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] eq, input logic [31:0] er, input bit edz, input int elat);
        int n;
        applyStimulus(usg, a, b, 0, n);
        $display("[TB] case %s", tag);
        checkOutput({tag, "_q"}, quotient, eq);
        checkOutput({tag, "_r"}, remainder, er);
        checkOutput({tag, "_dz"}, 32'(div_by_zero), 32'(edz));
        checkOutput({tag, "_lat"}, 32'(n), 32'(elat));
    endtask

    initial begin
        int  n;
        int  done_cnt;
        bit  seen;

        rst = 1'b1; start = 1'b0; usigned = 1'b0; dividend = '0; divisor = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_q", quotient, 32'd0);
        checkOutput("rst_r", remainder, 32'd0);
        checkOutput("rst_dz", 32'(div_by_zero), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        runCase("u100_7",    1'b1, 32'd100,      32'd7,          32'd14,        32'd2,        1'b0, FULL_LAT);
        runCase("s_m100_7",  1'b0, 32'hFFFFFF9C, 32'd7,          32'hFFFFFFF2,  32'hFFFFFFFE, 1'b0, FULL_LAT);
        runCase("s100_m7",   1'b0, 32'd100,      32'hFFFFFFF9,   32'hFFFFFFF2,  32'd2,        1'b0, FULL_LAT);
        runCase("uff_1",     1'b1, 32'hFFFFFFFF, 32'd1,          32'hFFFFFFFF,  32'd0,        1'b0, FULL_LAT);
        runCase("u8000_3",   1'b1, 32'h80000000, 32'd3,          32'h2AAAAAAA,  32'd2,        1'b0, FULL_LAT);
        runCase("s_m7_m2",   1'b0, 32'hFFFFFFF9, 32'hFFFFFFFE,   32'd3,         32'hFFFFFFFF, 1'b0, FULL_LAT);
        runCase("u5_9",      1'b1, 32'd5,        32'd9,          32'd0,         32'd5,        1'b0, FULL_LAT);
        runCase("s_dz",      1'b0, 32'h12345678, 32'd0,          32'hFFFFFFFF,  32'h12345678, 1'b1, SPEC_LAT);
        runCase("s_ovf",     1'b0, 32'h80000000, 32'hFFFFFFFF,   32'h80000000,  32'd0,        1'b0, SPEC_LAT);
        runCase("u_dz",      1'b1, 32'hFFFFFFF0, 32'd0,          32'hFFFFFFFF,  32'hFFFFFFF0, 1'b1, SPEC_LAT);
        runCase("u_noovf",   1'b1, 32'h80000000, 32'hFFFFFFFF,   32'd0,         32'h80000000, 1'b0, FULL_LAT);

        // start pulsed mid-operation must be ignored
        applyStimulus(1'b1, 32'd100, 32'd7, 5, n);
        checkOutput("ign_q", quotient, 32'd14);
        checkOutput("ign_r", remainder, 32'd2);
        checkOutput("ign_lat", 32'(n), 32'(FULL_LAT));
        @(posedge clk);
        #1;
        checkOutput("ign_idle_busy", 32'(busy), 32'd0);

        // back-to-back: second operation issued while in DONE
        @(negedge clk);
        applyStimulus(1'b0, 32'd100, 32'hFFFFFFF9, 0, n);
        checkOutput("b2b_first_q", quotient, 32'hFFFFFFF2);
        usigned = 1'b1; dividend = 32'd1000; divisor = 32'd3; start = 1'b1;
        waitForDone(0, n, seen);
        checkOutput("b2b_seen", 32'(seen), 32'd1);
        checkOutput("b2b_lat", 32'(n), 32'(FULL_LAT));
        checkOutput("b2b_q", quotient, 32'd333);
        checkOutput("b2b_r", remainder, 32'd1);

        // reset during ITER aborts immediately with no done
        @(negedge clk);
        usigned = 1'b1; dividend = 32'd50; divisor = 32'd4; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        checkOutput("mid_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_done", 32'(done), 32'd0);
        checkOutput("abort_q", quotient, 32'd0);
        checkOutput("abort_r", remainder, 32'd0);
        checkOutput("abort_dz", 32'(div_by_zero), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            if (done) done_cnt++;
        end
        checkOutput("abort_no_done", 32'(done_cnt), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
